tsbus_arb: RTL and testbench

TSBUS_ARB -- requirements
Module: tsbus_arb

---
 rtl/tsbus_arb_pkg.sv | 22 ++
 rtl/tsbus_arb_pick.sv | 40 ++++
 rtl/tsbus_arb.sv | 175 +++++++++++++++++
 tb/tb_tsbus_arb.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsbus_arb_pkg.sv
// Shared types and defaults for the tristate bus arbiter.
// State encoding, counter widths and index-width helper.
package tsbus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  localparam int N_DEF        = 4;
  localparam int TURN_CYC_DEF = 1;
  localparam int MAX_HOLD_DEF = 16;

  localparam int HOLD_W = 8;
  localparam int TURN_W = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tsbus_arb_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or after ptr_i, cyclic.
module rr_pick
  import tsbus_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         vld_o,
  output logic [W-1:0] idx_o
);

  localparam int W1 = W + 1;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W1-1:0]  sum;

  assign dbl = {req_i, req_i};
  assign rot = N'(dbl >> ptr_i);

  // Scan offsets high to low so the smallest offset wins.
  always_comb begin
    vld_o = 1'b0;
    sum   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        vld_o = 1'b1;
        sum   = {1'b0, ptr_i} + W1'(i);
      end
    end
    if (sum >= W1'(N)) begin
      sum = sum - W1'(N);
    end
    idx_o = sum[W-1:0];
  end

endmodule

// File: rtl/tsbus_arb.sv
// Round-robin arbiter for a shared pulled-up tristate pad.
// Grants one requester, enforces turnaround, flags readback errors.
module tsbus_arb
  import tsbus_arb_pkg::*;
#(
  parameter  int N        = N_DEF,
  parameter  int TURN_CYC = TURN_CYC_DEF,
  parameter  int MAX_HOLD = MAX_HOLD_DEF,
  localparam int W        = idx_w(N)
) (
  input  logic         CK,
  input  logic         RSTN,
  input  logic [N-1:0] REQ,
  input  logic [N-1:0] DAT,
  input  logic         PAD_O,
  input  logic         ERR_CLR,
  output logic [N-1:0] GNT,
  output logic [W-1:0] OWNER,
  output logic         PAD_I,
  output logic         PAD_T,
  output logic         BUSY,
  output logic         ERR
);

  localparam logic [HOLD_W-1:0] HOLD_MAX =
    HOLD_W'(MAX_HOLD);
  localparam logic [TURN_W-1:0] TURN_LAST =
    TURN_W'(TURN_CYC);
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  state_e              state_q, state_d;
  logic [N-1:0]        gnt_q, gnt_d;
  logic [W-1:0]        owner_q, owner_d;
  logic [W-1:0]        rr_q, rr_d;
  logic                pad_i_q, pad_i_d;
  logic                pad_t_q, pad_t_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TURN_W-1:0]   turn_q, turn_d;

  logic                pick_vld;
  logic [W-1:0]        pick_idx;
  logic                arb;
  logic                err_set;
  logic                others;
  logic                release_now;

  rr_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .req_i (REQ),
    .ptr_i (rr_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  assign others = |(REQ & ~gnt_q);

  assign release_now =
    !REQ[owner_q] ||
    ((hold_q == HOLD_MAX) && others);

  // State and registered outputs.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      pad_i_q <= 1'b1;
      pad_t_q <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      pad_i_q <= pad_i_d;
      pad_t_q <= pad_t_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  // Next state: grant, forced/voluntary release, turnaround.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    pad_i_d = pad_i_q;
    pad_t_d = pad_t_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    arb     = 1'b0;
    err_set = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        arb = pick_vld;
      end
      ST_GRANT: begin
        // First cycle skipped: pad may still be settling.
        err_set = (hold_q >= HOLD_W'(2)) &&
                  (PAD_O != pad_i_q);
        if (release_now) begin
          state_d = ST_TURN;
          gnt_d   = '0;
          pad_t_d = 1'b1;
          pad_i_d = 1'b1;
          hold_d  = '0;
          turn_d  = TURN_W'(1);
        end else begin
          pad_i_d = DAT[owner_q];
          if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) begin
          turn_d = '0;
          if (pick_vld) begin
            arb = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        pad_t_d = 1'b1;
        pad_i_d = 1'b1;
        hold_d  = '0;
        turn_d  = '0;
      end
    endcase

    if (arb) begin
      state_d           = ST_GRANT;
      gnt_d             = '0;
      gnt_d[pick_idx]   = 1'b1;
      owner_d           = pick_idx;
      pad_t_d           = 1'b0;
      pad_i_d           = DAT[pick_idx];
      hold_d            = HOLD_W'(1);
      rr_d = (pick_idx == LAST_IDX) ?
             '0 : pick_idx + W'(1);
    end
  end

  // Sticky error: set wins over clear.
  always_comb begin
    err_d  = err_set | (err_q & ~ERR_CLR);
    busy_d = (state_d != ST_IDLE);
  end

  assign GNT   = gnt_q;
  assign OWNER = owner_q;
  assign PAD_I = pad_i_q;
  assign PAD_T = pad_t_q;
  assign BUSY  = busy_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_tsbus_arb.sv
// Bench for tsbus_arb: directed scenarios plus random traffic
// against an owner/countdown reference model, two configurations.
module tb_tsbus_arb;

  logic       CK = 1'b0;
  logic       RSTN = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] dat = '0;
  logic       clr = 1'b0;
  logic       pado0 = 1'b1;
  logic       pado1 = 1'b1;

  logic [3:0] gnt0;
  logic [1:0] own0;
  logic       pt0, pi0, busy0, err0;
  logic [2:0] gnt1;
  logic [1:0] own1;
  logic       pt1, pi1, busy1, err1;

  int total = 0;
  int bad   = 0;

  int NN[2] = '{4, 3};
  int TC[2] = '{1, 3};
  int MH[2] = '{4, 5};

  int m_own[2];
  int m_last[2];
  int m_held[2];
  int m_gap[2];
  int m_ptr[2];
  bit m_pad[2];
  bit m_err[2];
  bit fault[2];

  always #5 CK = ~CK;

  tsbus_arb #(
    .N(4), .TURN_CYC(1), .MAX_HOLD(4)
  ) u0 (
    .CK(CK), .RSTN(RSTN), .REQ(req), .DAT(dat),
    .PAD_O(pado0), .ERR_CLR(clr),
    .GNT(gnt0), .OWNER(own0), .PAD_I(pi0),
    .PAD_T(pt0), .BUSY(busy0), .ERR(err0)
  );

  tsbus_arb #(
    .N(3), .TURN_CYC(3), .MAX_HOLD(5)
  ) u1 (
    .CK(CK), .RSTN(RSTN), .REQ(req[2:0]),
    .DAT(dat[2:0]),
    .PAD_O(pado1), .ERR_CLR(clr),
    .GNT(gnt1), .OWNER(own1), .PAD_I(pi1),
    .PAD_T(pt1), .BUSY(busy1), .ERR(err1)
  );

  task automatic model_reset(input int k);
    m_own[k]  = -1;
    m_last[k] = 0;
    m_held[k] = 0;
    m_gap[k]  = 0;
    m_ptr[k]  = 0;
    m_pad[k]  = 1'b1;
    m_err[k]  = 1'b0;
  endtask

  task automatic model_grant(input int k,
                             input logic [3:0] r);
    bit found;
    int j;
    found = 1'b0;
    for (int i = 0; i < NN[k]; i++) begin
      j = (m_ptr[k] + i) % NN[k];
      if (!found && r[j]) begin
        found     = 1'b1;
        m_own[k]  = j;
        m_last[k] = j;
        m_held[k] = 1;
        m_pad[k]  = dat[j];
        m_ptr[k]  = (j + 1) % NN[k];
      end
    end
  endtask

  task automatic model_edge();
    logic [3:0] r;
    logic [3:0] rest;
    bit po;
    bit set;
    for (int k = 0; k < 2; k++) begin
      r  = req & 4'((1 << NN[k]) - 1);
      po = (k == 0) ? pado0 : pado1;
      if (!RSTN) begin
        model_reset(k);
      end else begin
        set = (m_own[k] >= 0) && (m_held[k] >= 2) &&
              (po != m_pad[k]);
        if (m_own[k] >= 0) begin
          rest = r & ~(4'b1 << m_own[k]);
          if (!r[m_own[k]] ||
              (m_held[k] == MH[k] && rest != 0)) begin
            m_own[k]  = -1;
            m_gap[k]  = TC[k];
            m_pad[k]  = 1'b1;
            m_held[k] = 0;
          end else begin
            if (m_held[k] < MH[k]) m_held[k]++;
            m_pad[k] = dat[m_own[k]];
          end
        end else if (m_gap[k] > 0) begin
          m_gap[k]--;
          if (m_gap[k] == 0) model_grant(k, r);
        end else begin
          model_grant(k, r);
        end
        m_err[k] = set | (m_err[k] & !clr);
      end
    end
  endtask

  function automatic logic [9:0] exp_vec(input int k);
    logic [3:0] g;
    g = '0;
    if (m_own[k] >= 0) g[m_own[k]] = 1'b1;
    return {g, 2'(m_last[k]), m_own[k] < 0, m_pad[k],
            (m_own[k] >= 0 || m_gap[k] > 0), m_err[k]};
  endfunction

  task automatic drive_pad();
    pado0 = (m_own[0] < 0 ? 1'b1 : m_pad[0]) ^ fault[0];
    pado1 = (m_own[1] < 0 ? 1'b1 : m_pad[1]) ^ fault[1];
  endtask

  task automatic cyc();
    @(posedge CK);
    model_edge();
    #1;
    drive_pad();
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    req = '0;
    clr = 1'b0;
    fault[0] = 1'b0;
    fault[1] = 1'b0;
    drive_pad();
    cyc();
    cyc();
    RSTN = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] o1;
    RSTN = 1'b0;
    req = 4'($urandom);
    dat = 4'($urandom);
    for (int c = 0; c < 3; c++) begin
      cyc();
      total++;
      if ({gnt0, own0, pt0, pi0, busy0, err0} !==
          10'b0000_00_1_1_0_0) begin
        bad++;
        $display("FAIL reset c=%0d got=%b want=%b", c,
                 {gnt0, own0, pt0, pi0, busy0, err0},
                 10'b0000_00_1_1_0_0);
      end
      o1 = {1'b0, gnt1, own1, pt1, pi1, busy1, err1};
      total++;
      if (o1 !== exp_vec(1)) begin
        bad++;
        $display("FAIL reset_u1 got=%b want=%b",
                 o1, exp_vec(1));
      end
    end
    RSTN = 1'b1;
    req = '0;
  endtask

  task automatic test_single_grant();
    do_reset();
    req = 4'b0010;
    dat = 4'b1101;
    cyc();
    total++;
    if ({gnt0, pt0, pi0, busy0} !== 7'b0010_0_0_1) begin
      bad++;
      $display("FAIL single_grant got=%b want=%b",
               {gnt0, pt0, pi0, busy0}, 7'b0010_0_0_1);
    end
    for (int c = 0; c < 4; c++) begin
      cyc();
      total++;
      if ({pt0, pi0} !== 2'b00) begin
        bad++;
        $display("FAIL single_hold c=%0d got=%b want=00",
                 c, {pt0, pi0});
      end
    end
    dat = 4'b0010;
    cyc();
    total++;
    if (pi0 !== 1'b1) begin
      bad++;
      $display("FAIL single_dat got=%b want=1", pi0);
    end
    dat = 4'b1111;
    cyc();
    dat = 4'b0011;
    cyc();
    total++;
    if ({pt0, pi0, gnt0} !== 6'b0_1_0010) begin
      bad++;
      $display("FAIL single_nonowner got=%b want=%b",
               {pt0, pi0, gnt0}, 6'b0_1_0010);
    end
    req = 4'b0000;
    cyc();
    total++;
    if ({gnt0, pt0, pi0, busy0} !== 7'b0000_1_1_1) begin
      bad++;
      $display("FAIL single_release got=%b want=%b",
               {gnt0, pt0, pi0, busy0}, 7'b0000_1_1_1);
    end
    cyc();
    total++;
    if ({busy0, own0} !== 3'b0_01) begin
      bad++;
      $display("FAIL single_idle got=%b want=001",
               {busy0, own0});
    end
  endtask

  task automatic test_rr_rotation();
    logic [3:0] eg;
    logic       et;
    int         eo;
    do_reset();
    req = 4'hF;
    dat = 4'h5;
    for (int c = 0; c < 25; c++) begin
      cyc();
      eo = (c / 5) % 4;
      et = ((c % 5) == 4);
      eg = et ? 4'b0 : (4'b1 << eo);
      total++;
      if ({gnt0, own0, pt0} !== {eg, 2'(eo), et}) begin
        bad++;
        $display("FAIL rr c=%0d got=%b want=%b", c,
                 {gnt0, own0, pt0}, {eg, 2'(eo), et});
      end
    end
    req = '0;
  endtask

  task automatic test_sole_hold();
    logic [9:0] o1;
    do_reset();
    req = 4'b0100;
    cyc();
    for (int c = 0; c < 40; c++) begin
      dat = 4'($urandom);
      cyc();
      total++;
      if ({gnt0, pt0, busy0} !== 6'b0100_0_1) begin
        bad++;
        $display("FAIL sole c=%0d got=%b want=%b", c,
                 {gnt0, pt0, busy0}, 6'b0100_0_1);
      end
      o1 = {1'b0, gnt1, own1, pt1, pi1, busy1, err1};
      total++;
      if (o1 !== exp_vec(1)) begin
        bad++;
        $display("FAIL sole_u1 c=%0d got=%b want=%b", c,
                 o1, exp_vec(1));
      end
    end
    req = '0;
  endtask

  task automatic test_err();
    do_reset();
    req = 4'b0001;
    dat = 4'b0001;
    cyc();
    fault[0] = 1'b1;
    drive_pad();
    cyc();
    total++;
    if (err0 !== 1'b0) begin
      bad++;
      $display("FAIL err_first_cycle got=%b want=0", err0);
    end
    cyc();
    total++;
    if (err0 !== 1'b1) begin
      bad++;
      $display("FAIL err_set got=%b want=1", err0);
    end
    fault[0] = 1'b0;
    drive_pad();
    for (int c = 0; c < 3; c++) begin
      cyc();
      total++;
      if (err0 !== 1'b1) begin
        bad++;
        $display("FAIL err_sticky c=%0d got=%b want=1",
                 c, err0);
      end
    end
    clr = 1'b1;
    cyc();
    total++;
    if (err0 !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got=%b want=0", err0);
    end
    fault[0] = 1'b1;
    drive_pad();
    cyc();
    total++;
    if (err0 !== 1'b1) begin
      bad++;
      $display("FAIL err_set_clr got=%b want=1", err0);
    end
    clr = 1'b0;
    fault[0] = 1'b0;
    drive_pad();
    req = '0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b1000;
    dat = 4'b0000;
    cyc();
    total++;
    if (gnt0 !== 4'b1000) begin
      bad++;
      $display("FAIL mid_owner3 got=%b want=1000", gnt0);
    end
    cyc();
    cyc();
    RSTN = 1'b0;
    cyc();
    total++;
    if ({gnt0, own0, pt0, pi0, busy0} !==
        9'b0000_00_1_1_0) begin
      bad++;
      $display("FAIL mid_reset got=%b want=%b",
               {gnt0, own0, pt0, pi0, busy0},
               9'b0000_00_1_1_0);
    end
    RSTN = 1'b1;
    req = 4'b1001;
    cyc();
    total++;
    if ({gnt0, own0} !== 6'b0001_00) begin
      bad++;
      $display("FAIL mid_regrant got=%b want=000100",
               {gnt0, own0});
    end
    req = '0;
  endtask

  task automatic test_random();
    logic [9:0] o0;
    logic [9:0] o1;
    int b;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        b = $urandom_range(0, 3);
        req[b] = ~req[b];
      end
      dat = 4'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      fault[0] = ($urandom_range(0, 19) == 0);
      fault[1] = ($urandom_range(0, 19) == 0);
      RSTN = ($urandom_range(0, 299) != 0);
      drive_pad();
      cyc();
      o0 = {gnt0, own0, pt0, pi0, busy0, err0};
      o1 = {1'b0, gnt1, own1, pt1, pi1, busy1, err1};
      total++;
      if (o0 !== exp_vec(0)) begin
        bad++;
        $display("FAIL rand_u0 c=%0d got=%b want=%b", c,
                 o0, exp_vec(0));
      end
      total++;
      if (o1 !== exp_vec(1)) begin
        bad++;
        $display("FAIL rand_u1 c=%0d got=%b want=%b", c,
                 o1, exp_vec(1));
      end
      total++;
      if (!$onehot0(gnt0) || (pt0 === 1'b0 &&
          gnt0 === 4'b0)) begin
        bad++;
        $display("FAIL rand_inv c=%0d gnt=%b pad_t=%b",
                 c, gnt0, pt0);
      end
    end
    RSTN = 1'b1;
    clr = 1'b0;
    fault[0] = 1'b0;
    fault[1] = 1'b0;
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    fault[0] = 1'b0;
    fault[1] = 1'b0;
    test_reset();
    test_single_grant();
    test_rr_rotation();
    test_sole_hold();
    test_err();
    test_reset_mid_grant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
